// File: rtl/w_bit_serializer.sv
// Bit-serial weight loader: takes one packed word of N column weights and pushes them
// LSB first into the N per-column 1-bit weight FIFOs, all columns in lockstep.
module w_bit_serializer #(
    parameter int unsigned N        = 2,
    parameter int unsigned MAX_PREC = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            precision,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*MAX_PREC-1:0] w_word,
    input  logic [N-1:0]          fifo_full,
    output logic                  wr_en,
    output logic [N-1:0]          w_dout,
    output logic                  busy,
    output logic [CNT_W-1:0]      words_sent
);

    localparam int unsigned PW = $clog2(MAX_PREC + 1);
    localparam int unsigned IW = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         prec_q, prec_d;
    logic [PW-1:0]         prec_in;
    logic [MAX_PREC-1:0]   slot_q [N];
    logic [MAX_PREC-1:0]   slot_d [N];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_bit;
    logic                  accept;

    // Zero or out-of-range precision means full width.
    always_comb begin
        prec_in = PW'(precision);
        if (precision == 4'd0 || 32'(precision) > MAX_PREC) begin
            prec_in = PW'(MAX_PREC);
        end
    end

    // One shared full check keeps every column on the same bit index.
    always_comb begin
        wr_en    = 1'b0;
        busy     = 1'b0;
        in_ready = 1'b0;
        last_bit = 1'b0;
        w_dout   = '0;
        if (!rst) begin
            busy     = (state_q == StShift);
            wr_en    = busy && (fifo_full == '0);
            last_bit = wr_en && (32'(idx_q) + 32'd1 == 32'(prec_q));
            in_ready = (state_q == StIdle) || last_bit;
            if (busy) begin
                for (int c = 0; c < N; c++) begin
                    w_dout[c] = slot_q[c][idx_q];
                end
            end
        end
    end

    assign accept     = in_valid && in_ready;
    assign words_sent = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        prec_d  = prec_q;
        cnt_d   = cnt_q;
        for (int c = 0; c < N; c++) begin
            slot_d[c] = slot_q[c];
        end

        if (accept) begin
            state_d = StShift;
            idx_d   = '0;
            prec_d  = prec_in;
            for (int c = 0; c < N; c++) begin
                slot_d[c] = w_word[c*MAX_PREC +: MAX_PREC];
            end
        end else if (last_bit) begin
            state_d = StIdle;
            idx_d   = '0;
        end else if (wr_en) begin
            idx_d = idx_q + IW'(1);
        end

        if (last_bit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            prec_q  <= PW'(MAX_PREC);
            cnt_q   <= '0;
            for (int c = 0; c < N; c++) begin
                slot_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prec_q  <= prec_d;
            cnt_q   <= cnt_d;
            for (int c = 0; c < N; c++) begin
                slot_q[c] <= slot_d[c];
            end
        end
    end

endmodule
